core_mem_arbiter: RTL and testbench

//  Round-robin arbiter giving NUM_CORES matrix-multiply cores shared access to one single-port data memory.

---
 rtl/core_mem_arbiter_pkg.sv | 15 +
 rtl/core_mem_arbiter_if.sv | 30 +++
 rtl/core_mem_arbiter_rr_pick.sv | 23 ++
 rtl/core_mem_arbiter.sv | 110 +++++++++++
 tb/tb_core_mem_arbiter.sv | 172 +++++++++++++++++
 5 files changed

// File: rtl/core_mem_arbiter_pkg.sv
// core_mem_arbiter_pkg: shared defaults, FSM encoding and wrap helper for the memory arbiter
package core_mem_arbiter_pkg;
  localparam int NUM_CORES_DEF = 4;
  localparam int ADDR_W_DEF = 16;
  localparam int DATA_W_DEF = 8;
  localparam int MEM_LAT_DEF = 2;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_e;
  function automatic int rr_wrap(input int v, input int n);
    return (v >= n) ? v - n : v;
  endfunction
endpackage

// File: rtl/core_mem_arbiter_if.sv
// core_mem_arbiter_if: core request/response bus plus memory port of the shared-memory arbiter
interface core_mem_arbiter_if
  import core_mem_arbiter_pkg::*;
#(
  parameter int NUM_CORES = NUM_CORES_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
);
  logic [NUM_CORES-1:0] req;
  logic [NUM_CORES-1:0] we;
  logic [NUM_CORES*ADDR_W-1:0] addr;
  logic [NUM_CORES*DATA_W-1:0] wdata;
  logic [NUM_CORES-1:0] gnt;
  logic [NUM_CORES-1:0] rvalid;
  logic [DATA_W-1:0] rdata;
  logic mem_en;
  logic mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic busy;
  modport master (
    output req, we, addr, wdata, mem_rdata,
    input gnt, rvalid, rdata, mem_en, mem_we, mem_addr, mem_wdata, busy
  );
  modport slave (
    input req, we, addr, wdata, mem_rdata,
    output gnt, rvalid, rdata, mem_en, mem_we, mem_addr, mem_wdata, busy
  );
endinterface

// File: rtl/core_mem_arbiter_rr_pick.sv
// core_mem_arbiter_rr_pick: first requester at or after ptr, scanning with wrap
module core_mem_arbiter_rr_pick
  import core_mem_arbiter_pkg::*;
#(
  parameter int NUM_CORES = NUM_CORES_DEF,
  localparam int IW = $clog2(NUM_CORES)
) (
  input  logic [NUM_CORES-1:0] req_i,
  input  logic [IW-1:0]        ptr_i,
  output logic [NUM_CORES-1:0] sel_o,
  output logic [IW-1:0]        idx_o,
  output logic                 any_o
);
  // Scan from the farthest offset down so the nearest requester wins
  always_comb begin
    idx_o = '0;
    for (int k = NUM_CORES - 1; k >= 0; k--)
      if (req_i[IW'(rr_wrap(int'(ptr_i) + k, NUM_CORES))])
        idx_o = IW'(rr_wrap(int'(ptr_i) + k, NUM_CORES));
  end
  assign any_o = |req_i;
  assign sel_o = any_o ? NUM_CORES'(1) << idx_o : '0;
endmodule

// File: rtl/core_mem_arbiter.sv
// core_mem_arbiter: round-robin arbiter serialising core accesses onto one single-port memory
module core_mem_arbiter
  import core_mem_arbiter_pkg::*;
#(
  parameter int NUM_CORES = NUM_CORES_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int MEM_LAT = MEM_LAT_DEF
) (
  input logic clk,
  input logic reset_n,
  core_mem_arbiter_if.slave bus
);
  localparam int IW = $clog2(NUM_CORES);
  localparam int LW = $clog2(MEM_LAT + 1);
  state_e state_q, state_d;
  logic [IW-1:0] ptr_q, ptr_d, win_q, win_d, pick_idx;
  logic [NUM_CORES-1:0] pick_sel, gnt_q, gnt_d, rvalid_q, rvalid_d;
  logic pick_any, en_q, en_d, we_q, we_d;
  logic [LW-1:0] lat_q, lat_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
  logic [ADDR_W-1:0] addr_a [NUM_CORES];
  logic [DATA_W-1:0] wdata_a [NUM_CORES];
  for (genvar g = 0; g < NUM_CORES; g++) begin : g_unpack
    assign addr_a[g] = bus.addr[g*ADDR_W +: ADDR_W];
    assign wdata_a[g] = bus.wdata[g*DATA_W +: DATA_W];
  end
  core_mem_arbiter_rr_pick #(.NUM_CORES(NUM_CORES)) u_pick (
    .req_i(bus.req),
    .ptr_i(ptr_q),
    .sel_o(pick_sel),
    .idx_o(pick_idx),
    .any_o(pick_any)
  );
  always_comb begin
    state_d = state_q;
    ptr_d = ptr_q;
    win_d = win_q;
    lat_d = lat_q;
    gnt_d = '0;
    rvalid_d = '0;
    en_d = 1'b0;
    we_d = we_q;
    addr_d = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: if (pick_any) begin
        state_d = ISSUE;
        win_d = pick_idx;
        gnt_d = pick_sel;
        en_d = 1'b1;
        we_d = bus.we[pick_idx];
        addr_d = addr_a[pick_idx];
        wdata_d = wdata_a[pick_idx];
      end
      ISSUE: begin
        ptr_d = IW'(rr_wrap(int'(win_q) + 1, NUM_CORES));
        we_d = 1'b0;
        state_d = we_q ? IDLE : WAIT;
        lat_d = we_q ? '0 : LW'(1);
      end
      WAIT: begin
        lat_d = lat_q + LW'(1);
        if (lat_q == LW'(MEM_LAT)) begin
          rdata_d = bus.mem_rdata;
          rvalid_d = NUM_CORES'(1) << win_q;
          state_d = IDLE;
          lat_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state_q <= IDLE;
      ptr_q <= '0;
      win_q <= '0;
      lat_q <= '0;
      gnt_q <= '0;
      rvalid_q <= '0;
      en_q <= 1'b0;
      we_q <= 1'b0;
      addr_q <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q <= ptr_d;
      win_q <= win_d;
      lat_q <= lat_d;
      gnt_q <= gnt_d;
      rvalid_q <= rvalid_d;
      en_q <= en_d;
      we_q <= we_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  assign bus.gnt = gnt_q;
  assign bus.rvalid = rvalid_q;
  assign bus.rdata = rdata_q;
  assign bus.mem_en = en_q;
  assign bus.mem_we = we_q;
  assign bus.mem_addr = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.busy = state_q != IDLE;
endmodule

// File: tb/tb_core_mem_arbiter.sv
// tb_core_mem_arbiter: randomized scoreboard bench with a transaction-level round-robin model
module tb_core_mem_arbiter #(parameter int MEM_LAT = 2);
  localparam int NUM_CORES = 4;
  localparam int ADDR_W = 16;
  localparam int DATA_W = 8;
  typedef struct {logic w; logic [ADDR_W-1:0] a; logic [DATA_W-1:0] d;} txn_t;
  typedef struct {int c; logic [DATA_W-1:0] d; longint due;} rd_t;
  logic clk, reset_n;
  int compared = 0, mismatched = 0;
  txn_t exp_q [NUM_CORES][$];
  rd_t inflight [$];
  longint t = 0, next_free = 0;
  int ptr_m = 0, c;
  logic [NUM_CORES-1:0] req_prev, exp_g, oh;
  txn_t tx;
  rd_t rd;
  logic [DATA_W-1:0] pipe [MEM_LAT];
  core_mem_arbiter_if #(.NUM_CORES(NUM_CORES), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();
  core_mem_arbiter #(.NUM_CORES(NUM_CORES), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_LAT(MEM_LAT)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  function automatic logic [DATA_W-1:0] mem_f(input logic [ADDR_W-1:0] a);
    return a[7:0] ^ a[15:8] ^ 8'hE5;
  endfunction
  // Memory returns a fixed function of the address MEM_LAT cycles after mem_en, noise otherwise
  always @(posedge clk) begin
    pipe[0] <= (bus.mem_en && !bus.mem_we) ? mem_f(bus.mem_addr) : DATA_W'($urandom);
    for (int k = 1; k < MEM_LAT; k++) pipe[k] <= pipe[k-1];
  end
  assign bus.mem_rdata = pipe[MEM_LAT-1];
  function automatic int rr_winner(input logic [NUM_CORES-1:0] r, input int p);
    for (int k = 0; k < NUM_CORES; k++) if (r[(p + k) % NUM_CORES]) return (p + k) % NUM_CORES;
    return -1;
  endfunction
  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic txn(input int i, input logic w, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    int n = 0;
    bus.req[i] = 1'b1;
    bus.we[i] = w;
    bus.addr[i*ADDR_W +: ADDR_W] = a;
    bus.wdata[i*DATA_W +: DATA_W] = d;
    exp_q[i].push_back('{w, a, d});
    do begin step(); n++; end while (!bus.gnt[i] && n < 200);
    if (!bus.gnt[i]) chk($sformatf("gnt_timeout_core%0d", i), 0, 1);
    step();
    bus.req[i] = 1'b0;
  endtask
  // Model: a free cycle with pending requests yields a grant next cycle to the next core in rotation
  always @(negedge clk) begin
    t++;
    if (!reset_n) begin
      inflight.delete();
      ptr_m = 0;
      next_free = t + 1;
      req_prev = '0;
    end else begin
      exp_g = '0;
      c = -1;
      if (t - 1 >= next_free && req_prev != 0) begin
        c = rr_winner(req_prev, ptr_m);
        exp_g = NUM_CORES'(1) << c;
      end
      if (exp_g != 0 || bus.gnt != 0 || bus.mem_en) chk("gnt", {bus.gnt, bus.mem_en}, {exp_g, |exp_g});
      if (c >= 0) begin
        ptr_m = (c + 1) % NUM_CORES;
        next_free = t + 1;
        if (exp_q[c].size() == 0) chk("grant_without_request", 0, 1);
        else begin
          tx = exp_q[c].pop_front();
          chk("mem_cmd", {bus.mem_we, bus.mem_addr, bus.mem_wdata}, {tx.w, tx.a, tx.d});
          if (!tx.w) begin
            next_free = t + 1 + MEM_LAT;
            inflight.push_back('{c, mem_f(tx.a), t + 1 + MEM_LAT});
          end
        end
      end
      if (bus.rvalid != 0 || (inflight.size() != 0 && inflight[0].due == t)) begin
        if (inflight.size() == 0) chk("rvalid_spurious", bus.rvalid, 0);
        else begin
          rd = inflight.pop_front();
          oh = NUM_CORES'(1) << rd.c;
          chk("rvalid", {bus.rvalid, bus.rdata, 64'(t)}, {oh, rd.d, 64'(rd.due)});
        end
      end
      chk("busy", bus.busy, t < next_free);
      chk("onehot", {$onehot0(bus.gnt), $onehot0(bus.rvalid)}, 2'b11);
      req_prev = bus.req;
    end
  end
  task automatic do_reset();
    reset_n = 1'b0;
    repeat (2) step();
    reset_n = 1'b1;
  endtask
  initial begin
    reset_n = 1'b0;
    bus.req = '0;
    bus.we = '0;
    bus.addr = '0;
    bus.wdata = '0;
    repeat (3) step();
    chk("reset_outputs", {bus.gnt, bus.rvalid, bus.rdata, bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.busy}, 0);
    reset_n = 1'b1;
    repeat (2) step();
    txn(2, 1'b0, 16'h0040, 8'h00);
    repeat (MEM_LAT + 3) step();
    chk("read_a5_rdata_hold", bus.rdata, 8'hA5);
    txn(1, 1'b1, 16'h0010, 8'h3C);
    repeat (MEM_LAT + 3) step();
    do_reset();
    for (int k = 0; k < NUM_CORES; k++) begin
      automatic int kk = k;
      fork
        repeat (2) txn(kk, 1'b0, ADDR_W'($urandom), DATA_W'($urandom));
      join_none
    end
    wait fork;
    repeat (MEM_LAT + 3) step();
    txn(2, 1'b0, 16'h0123, 8'h00);
    repeat (MEM_LAT + 3) step();
    fork
      txn(0, 1'b0, 16'h0200, 8'h11);
      txn(2, 1'b1, 16'h0300, 8'h22);
    join
    repeat (MEM_LAT + 3) step();
    txn(3, 1'b0, 16'h0777, 8'h00);
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_reset_outputs", {bus.gnt, bus.rvalid, bus.rdata, bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.busy}, 0);
    repeat (2) step();
    reset_n = 1'b1;
    repeat (MEM_LAT + 4) step();
    chk("busy_after_reset", bus.busy, 0);
    fork
      txn(1, 1'b0, 16'h0042, 8'h00);
      txn(3, 1'b1, 16'h0043, 8'h55);
    join
    repeat (MEM_LAT + 3) step();
    repeat (3) txn(0, 1'b0, ADDR_W'($urandom), 8'h00);
    repeat (MEM_LAT + 3) step();
    for (int k = 0; k < NUM_CORES; k++) begin
      automatic int kk = k;
      fork
        repeat (12) begin
          repeat ($urandom_range(0, 3)) step();
          txn(kk, 1'($urandom), ADDR_W'($urandom), DATA_W'($urandom));
        end
      join_none
    end
    wait fork;
    repeat (MEM_LAT + 4) step();
    for (int k = 0; k < NUM_CORES; k++) chk($sformatf("pending_core%0d", k), exp_q[k].size(), 0);
    chk("pending_reads", inflight.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
